// File: rtl/fpga_phase_gen.sv
// Multi-channel phase/tick generator: each channel divides clk by a runtime-loadable period.
// Optional single-step support is compiled in when PHASE_GEN_STEP_EN is defined.
module fpga_phase_gen #(
  parameter int          NUM_CH         = 2,
  parameter int          CNT_W          = 25,
  parameter int unsigned DEFAULT_PERIOD = 25174013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*CNT_W-1:0] i_period,
  input  logic [NUM_CH-1:0]       i_load,
  input  logic [NUM_CH-1:0]       i_enable,
  input  logic [NUM_CH-1:0]       i_step,
  input  logic                    i_sync,
  output logic [NUM_CH-1:0]       o_tick,
  output logic [NUM_CH-1:0]       o_phase,
  output logic [NUM_CH-1:0]       o_load_pend
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  logic [NUM_CH-1:0] step_ev;

`ifdef PHASE_GEN_STEP_EN
  assign step_ev = ~i_enable & i_step;
`else
  logic unused_step;
  assign unused_step = ^i_step;
  assign step_ev     = '0;
`endif

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             phase_q, phase_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] ld_val;
    logic             wrap;
    logic             event_w;

    assign ld_val  = i_period[n*CNT_W +: CNT_W];
    assign wrap    = i_enable[n] & (cnt_q == period_q);
    assign event_w = wrap | step_ev[n];

    always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      phase_d  = phase_q;
      tick_d   = 1'b0;
      if (i_sync) begin
        // Restart without a tick; any outstanding period is applied now.
        cnt_d   = '0;
        phase_d = 1'b0;
        pend_d  = 1'b0;
        if (i_load[n]) begin
          period_d = ld_val;
          shadow_d = ld_val;
        end else if (pend_q) begin
          period_d = shadow_q;
        end
      end else if (event_w) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        phase_d = ~phase_q;
        pend_d  = 1'b0;
        if (i_load[n]) begin
          period_d = ld_val;
          shadow_d = ld_val;
        end else if (pend_q) begin
          period_d = shadow_q;
        end
      end else begin
        if (i_enable[n]) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Deferred until the next event so an interval is never cut short.
        if (i_load[n]) begin
          shadow_d = ld_val;
          pend_d   = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        period_q <= DEF_P;
        shadow_q <= DEF_P;
        pend_q   <= 1'b0;
        phase_q  <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        period_q <= period_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        phase_q  <= phase_d;
        tick_q   <= tick_d;
      end
    end

    assign o_tick[n]      = tick_q;
    assign o_phase[n]     = phase_q;
    assign o_load_pend[n] = pend_q;
  end

endmodule

// File: doc/fpga_phase_gen.md
# fpga_phase_gen

Parametrised multi-channel phase/tick generator for the FPGA snake-game top level, replacing the hard-coded blink and game-phase counters. Each channel divides the pixel clock by a runtime-loadable period and produces a one-cycle tick and a toggling phase output. Channels can be paused, single-stepped and resynchronised. Typical use: channel 0 drives `game.i_phase`, channel 1 drives the heartbeat LED.

## Interface
Parameters:
- `NUM_CH`, 2, number of independent channels (1..8)
- `CNT_W`, 25, counter and period width in bits
- `DEFAULT_PERIOD`, 25174013, terminal count loaded into every channel at reset

Ports:
- `clk` in 1, pixel clock; the only clock
- `rst` in 1, reset, synchronous, active-high
- `i_period` in NUM_CH*CNT_W, per-channel terminal count; channel n uses bits [n*CNT_W +: CNT_W]; period = value+1 enabled cycles
- `i_load` in NUM_CH, per-channel write strobe for `i_period`
- `i_enable` in NUM_CH, per-channel run (1) / pause (0)
- `i_step` in NUM_CH, per-channel single-step request; honoured only while paused
- `i_sync` in 1, restarts all channels together
- `o_tick` out NUM_CH, one-cycle pulse per event
- `o_phase` out NUM_CH, toggles on every event
- `o_load_pend` out NUM_CH, loaded period not yet in effect

## Operation
- Per-channel state: `cnt`, `period`, `shadow`, `pend`, `phase`, `tick`. All are registers; outputs drive directly from them.
- An event is one of:
  - enabled and `cnt == period`: a wrap;
  - a step (see below).
- On an event:
  - `cnt <= 0`, `tick <= 1`, `phase <= ~phase`;
  - if `pend`: `period <= shadow`, `pend <= 0`.
- Enabled, no event: `cnt <= cnt + 1`, `tick <= 0`.
- Paused (`i_enable = 0`): `cnt` and `phase` hold; `tick <= 0` unless stepping.
- Load: `i_load[n]` writes `shadow <= i_period[n]` and sets `pend <= 1`.
  - The new value takes effect only at the next event, so a period change never produces a runt interval.
  - If load and an event coincide, `i_period[n]` goes directly to `period` and `pend` stays 0.
  - A second load before application overwrites `shadow`; only the last value counts.
- Step: `i_enable[n] = 0` and `i_step[n] = 1` forces an event that cycle. `i_step` held high gives one event per cycle. `i_step` while enabled is ignored.
- Sync, all channels:
  - `cnt <= 0`, `phase <= 0`, `tick <= 0`;
  - pending shadows are applied;
  - no tick is generated.
- Priority: `rst` > `i_sync` > load-with-event > step > wrap/count.
- Period 0: an event every enabled cycle; `tick` stays high continuously and `phase` toggles every cycle.
- Counter width: `cnt` never exceeds `period`, because `period` only changes at events or sync. No overflow handling is needed.

## Timing
- Reset values: `cnt = 0`, `period = shadow = DEFAULT_PERIOD`, `pend = 0`, `o_phase = 0`, `o_tick = 0`, `o_load_pend = 0`.
- First event: `o_tick` rises on the (P+1)th rising edge after `rst` is sampled low, with the channel enabled throughout.
- Steady state: events every P+1 enabled cycles. `o_tick` and the `o_phase` toggle appear on the same edge.
- Pause/resume: paused cycles are not counted; the interval stretches by exactly the paused cycle count.
- Step latency: `o_tick` is high on the edge after `i_step` is sampled.
- Load:
  - `o_load_pend` rises one cycle after `i_load`;
  - it falls on the same edge as the event that applies the value.
- Sync: all `o_phase` are 0 and all counters are 0 one cycle after `i_sync`.
- `rst` asserted mid-count returns all state to reset values on the next edge, including pending loads.

## Configuration
- `PHASE_GEN_STEP_EN` defined:
  - single-step logic is compiled in;
  - `i_step` behaves as in Operation.
- `PHASE_GEN_STEP_EN` not defined:
  - `i_step` is ignored;
  - a paused channel produces no events;
  - port list unchanged.

## Test plan
- Reset, then run: NUM_CH=2, DEFAULT_PERIOD=3, both channels enabled. Required: `o_tick` pulses on cycles 4, 8, 12 after reset release; `o_phase` reads 1, 0, 1.
- Period change: load 1 into ch0 at cycle 2 (period 3 active). Required: `o_load_pend[0] = 1`; next tick at cycle 4 with pend cleared; following ticks at 6, 8.
- Pause and step (macro defined): ch1 period 5, paused at `cnt = 2` for 10 cycles, then resumed. Required: tick arrives 10 cycles late. With a step pulse while paused: tick next cycle, `cnt` back to 0. Macro undefined: no tick on step.
- Sync: ch0 at `cnt = 2`, ch1 at `cnt = 4` with `phase = 1`. Pulse `i_sync`. Required: both channels at `cnt = 0`, phase 0, no tick; afterwards ticks are aligned.
- Period 0: load 0, enable. Required: `o_tick` constant 1; `o_phase` toggles every cycle.
- Mid-operation reset: `rst` while ch0 has a pending load of 7. Required: `period = DEFAULT_PERIOD`, `pend = 0`, all outputs 0 next cycle.
